mesi_cache_ctrl: RTL
====================

MESI_CACHE_CTRL -- requirements
Module: mesi_cache_ctrl

Interface
REQ-001 Parameter NUM_LINES, default 4, SHALL set the number of tracked lines (power of two, >=2).
REQ-002 Parameter ADDR_W, default $clog2(NUM_LINES), SHALL set the line-index width; it is derived, never overridden.
REQ-003 One clock, reset synchronous active-high: clk_i in 1, rising-edge clock; rst_i in 1, synchronous active-high reset.
REQ-004 pr_rd_i in 1: processor read request; pr_wr_i in 1: processor write request; pr_addr_i in ADDR_W: line index.
REQ-005 pr_ready_o out 1: one-cycle completion pulse; pr_hit_o out 1: valid with pr_ready_o, 1 = no bus transaction used.
REQ-006 bus_req_o out 1: bus request; bus_gnt_i in 1: grant; bus_cmd_o out 2: BusRd 00, BusRdX 01, BusUpgr 10, Flush 11; bus_addr_o out ADDR_W.
REQ-007 bus_shared_i in 1: another cache holds the line, sampled in the grant cycle.
REQ-008 snoop_valid_i in 1, snoop_cmd_i in 2, snoop_addr_i in ADDR_W: foreign bus transaction, same encoding as bus_cmd_o.
REQ-009 snoop_shared_o out 1: line held here; snoop_flush_o out 1: dirty data supplied.
REQ-010 state_o out 2*NUM_LINES: line states, line i at bits [2i+1:2i].

Function
REQ-011 Line states SHALL be I=00, S=01, E=10, M=11.
REQ-012 Controller FSM SHALL have states IDLE, WAIT_GNT, DONE.
REQ-013 A request is accepted in IDLE when pr_rd_i or pr_wr_i is high; both high is treated as a write; inputs are held stable until pr_ready_o.
REQ-014 Read hit (S/E/M) and write hit in M SHALL pulse pr_ready_o with pr_hit_o=1 on the cycle after acceptance, with no bus activity.
REQ-015 Write hit in E SHALL move the line E->M silently, with the same timing as REQ-014.
REQ-016 Miss or write-in-S SHALL go to WAIT_GNT and assert bus_req_o from the cycle after acceptance until the cycle bus_gnt_i is sampled high.
REQ-017 While in WAIT_GNT, bus_cmd_o SHALL follow the current line state:
- read, line I: BusRd
- write, line I: BusRdX
- write, line S: BusUpgr
REQ-018 On grant, the line SHALL update:
- BusRd: E if bus_shared_i=0, else S
- BusRdX: M
- BusUpgr: M
The FSM SHALL then enter DONE and pulse pr_ready_o with pr_hit_o=0 the next cycle, then return to IDLE.
REQ-019 Snoop response SHALL be registered, with outputs one cycle after snoop_valid_i:
- BusRd: M->S with flush; E->S; S stays S; shared=1 if the line was not I
- BusRdX: M->I with flush; E/S->I
- BusUpgr: S->I
- Flush: no change
REQ-020 A snoop to a line with an own request in WAIT_GNT SHALL apply first; a pending BusUpgr whose line becomes I SHALL be issued as BusRdX.
REQ-021 snoop_valid_i and bus_gnt_i high in the same cycle is a bus-protocol violation; the bench SHALL flag it, and the RTL gives the grant priority.
REQ-022 Snoops to lines other than the pending one SHALL never stall or alter the processor FSM.

Reset
REQ-023 Reset SHALL put all lines in I and the FSM in IDLE, and drive pr_ready_o, pr_hit_o, bus_req_o, bus_cmd_o, bus_addr_o, snoop_shared_o and snoop_flush_o to 0.
REQ-024 Reset mid-transaction SHALL abandon the request without a pr_ready_o pulse and drop bus_req_o in the next cycle.

Structure
REQ-025 Package mesi_pkg SHALL hold the line-state encodings, the bus command encodings and the FSM state type.
REQ-026 Per-line next-state logic (processor event plus snoop event to next state and flush/shared) SHALL live in sub-module mesi_line, instantiated NUM_LINES times.

Verification
REQ-027 Reset, then read line 2 with bus_shared_i=0 -> BusRd issued, line 2 = E, pr_hit_o=0; then write line 2 -> silent E->M, pr_hit_o=1, one-cycle latency.
REQ-028 Read line 1 with bus_shared_i=1 -> line 1 = S; then write line 1 -> BusUpgr issued, line 1 = M.
REQ-029 Line 3 in M, then snoop BusRd addr 3 -> snoop_flush_o=1 and snoop_shared_o=1 next cycle, line 3 = S; then snoop BusRdX addr 3 -> line 3 = I, no flush.
REQ-030 Line 0 in S, write line 0 with grant withheld, snoop BusUpgr addr 0 -> bus_cmd_o changes 10->01; grant -> line 0 = M.
REQ-031 Assert rst_i while in WAIT_GNT -> no pr_ready_o pulse, bus_req_o=0 the next cycle, all lines I.

Source files
------------

// File: rtl/mesi_pkg.sv
// rtl/mesi_pkg.sv - shared encodings for the MESI cache controller
//
// Purpose: line-state and bus-command encodings, the controller FSM state
// type, and the helper that picks the bus command for a pending miss.
// Ports: none (package).
package mesi_pkg;

    typedef enum logic [1:0] {
        LS_I = 2'b00,
        LS_S = 2'b01,
        LS_E = 2'b10,
        LS_M = 2'b11
    } line_state_t;

    typedef enum logic [1:0] {
        CMD_BUSRD   = 2'b00,
        CMD_BUSRDX  = 2'b01,
        CMD_BUSUPGR = 2'b10,
        CMD_FLUSH   = 2'b11
    } bus_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_WAIT_GNT = 2'b01,
        ST_DONE     = 2'b10
    } fsm_state_t;

    // A write only needs an upgrade while the line is still S; if a snoop has
    // invalidated it meanwhile the data must be fetched again with BusRdX.
    function automatic bus_cmd_t miss_cmd(input logic is_wr, input line_state_t st);
        if (!is_wr) begin
            return CMD_BUSRD;
        end
        return (st == LS_S) ? CMD_BUSUPGR : CMD_BUSRDX;
    endfunction

endpackage

// File: rtl/mesi_line.sv
// rtl/mesi_line.sv - next-state logic for one tracked cache line
//
// Purpose: combines this line's processor event (silent E->M upgrade or a
// granted bus transaction) with a foreign snoop into the next line state and
// the snoop responses.
// Ports:
//   i_state       current line state
//   i_pr_upgrade  write hit in E accepted this cycle
//   i_gnt         own bus transaction for this line granted this cycle
//   i_gnt_cmd     command of that transaction
//   i_gnt_shared  another cache holds the line (grant cycle)
//   i_snp         foreign transaction targets this line
//   i_snp_cmd     foreign command
//   o_next        next line state
//   o_flush       dirty data must be supplied
//   o_shared      line is held here
module mesi_line
    import mesi_pkg::*;
(
    input  line_state_t i_state,
    input  logic        i_pr_upgrade,
    input  logic        i_gnt,
    input  bus_cmd_t    i_gnt_cmd,
    input  logic        i_gnt_shared,
    input  logic        i_snp,
    input  bus_cmd_t    i_snp_cmd,
    output line_state_t o_next,
    output logic        o_flush,
    output logic        o_shared
);

    // The controller never raises two of the event inputs together for the
    // same line: a grant masks the snoop, and acceptance is deferred while a
    // snoop hits the requested line.
    always_comb begin
        o_next   = i_state;
        o_flush  = 1'b0;
        o_shared = 1'b0;
        if (i_gnt) begin
            if (i_gnt_cmd == CMD_BUSRD) begin
                o_next = i_gnt_shared ? LS_S : LS_E;
            end else begin
                o_next = LS_M;
            end
        end else if (i_pr_upgrade) begin
            o_next = LS_M;
        end else if (i_snp) begin
            unique case (i_snp_cmd)
                CMD_BUSRD: begin
                    o_shared = (i_state != LS_I);
                    o_flush  = (i_state == LS_M);
                    if (i_state != LS_I) begin
                        o_next = LS_S;
                    end
                end
                CMD_BUSRDX: begin
                    o_flush = (i_state == LS_M);
                    o_next  = LS_I;
                end
                CMD_BUSUPGR: begin
                    if (i_state == LS_S) begin
                        o_next = LS_I;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/mesi_cache_ctrl.sv
// rtl/mesi_cache_ctrl.sv - MESI coherence controller for a small line array
//
// Purpose: serves processor read/write requests against NUM_LINES tracked
// lines, issues BusRd/BusRdX/BusUpgr on misses, and answers foreign snoops.
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   pr_rd_i, pr_wr_i, pr_addr_i       processor request (held until ready)
//   pr_ready_o, pr_hit_o              completion pulse, 1 = no bus used
//   bus_req_o, bus_gnt_i              bus request / grant
//   bus_cmd_o, bus_addr_o             command and line of own transaction
//   bus_shared_i                      other cache holds the line (grant cycle)
//   snoop_valid_i/cmd_i/addr_i        foreign bus transaction
//   snoop_shared_o, snoop_flush_o     registered snoop response
//   state_o                           line states, line i at [2i+1:2i]
module mesi_cache_ctrl
    import mesi_pkg::*;
#(
    parameter int NUM_LINES = 4,
    parameter int ADDR_W    = $clog2(NUM_LINES)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   pr_rd_i,
    input  logic                   pr_wr_i,
    input  logic [ADDR_W-1:0]      pr_addr_i,
    output logic                   pr_ready_o,
    output logic                   pr_hit_o,
    output logic                   bus_req_o,
    input  logic                   bus_gnt_i,
    output logic [1:0]             bus_cmd_o,
    output logic [ADDR_W-1:0]      bus_addr_o,
    input  logic                   bus_shared_i,
    input  logic                   snoop_valid_i,
    input  logic [1:0]             snoop_cmd_i,
    input  logic [ADDR_W-1:0]      snoop_addr_i,
    output logic                   snoop_shared_o,
    output logic                   snoop_flush_o,
    output logic [2*NUM_LINES-1:0] state_o
);

    fsm_state_t        r_fsm;
    fsm_state_t        w_fsm_next;
    logic [ADDR_W-1:0] r_addr;
    logic              r_is_wr;
    logic              r_hit;
    logic              r_snoop_shared;
    logic              r_snoop_flush;

    line_state_t       r_line      [NUM_LINES];
    line_state_t       w_line_next [NUM_LINES];
    logic [NUM_LINES-1:0] w_flush;
    logic [NUM_LINES-1:0] w_shared;

    logic              w_req;
    logic              w_accept;
    logic              w_accept_hit;
    logic              w_upgrade_e;
    logic              w_gnt;
    logic              w_snp_valid;
    line_state_t       w_req_state;
    line_state_t       w_pend_state;
    bus_cmd_t          w_pend_cmd;

    assign w_req        = pr_rd_i | pr_wr_i;
    assign w_req_state  = r_line[pr_addr_i];
    assign w_pend_state = r_line[r_addr];
    assign w_pend_cmd   = miss_cmd(r_is_wr, w_pend_state);
    assign w_gnt        = (r_fsm == ST_WAIT_GNT) && bus_gnt_i;
    // A snoop coinciding with our grant is illegal on the bus; the grant wins.
    assign w_snp_valid  = snoop_valid_i && !w_gnt;
    assign w_upgrade_e  = w_accept_hit && pr_wr_i && (w_req_state == LS_E);

    always_comb begin
        w_fsm_next   = r_fsm;
        w_accept     = 1'b0;
        w_accept_hit = 1'b0;
        unique case (r_fsm)
            ST_IDLE: begin
                // Defer acceptance for one cycle if a snoop is changing the
                // requested line, so the hit decision sees the settled state.
                if (w_req && !(w_snp_valid && (snoop_addr_i == pr_addr_i))) begin
                    w_accept = 1'b1;
                    if (pr_wr_i ? ((w_req_state == LS_E) || (w_req_state == LS_M))
                                : (w_req_state != LS_I)) begin
                        w_accept_hit = 1'b1;
                        w_fsm_next   = ST_DONE;
                    end else begin
                        w_fsm_next   = ST_WAIT_GNT;
                    end
                end
            end
            ST_WAIT_GNT: begin
                if (bus_gnt_i) begin
                    w_fsm_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_fsm_next = ST_IDLE;
            end
            default: begin
                w_fsm_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fsm          <= ST_IDLE;
            r_addr         <= '0;
            r_is_wr        <= 1'b0;
            r_hit          <= 1'b0;
            r_snoop_shared <= 1'b0;
            r_snoop_flush  <= 1'b0;
            for (int i = 0; i < NUM_LINES; i++) begin
                r_line[i] <= LS_I;
            end
        end else begin
            r_fsm          <= w_fsm_next;
            r_snoop_shared <= |w_shared;
            r_snoop_flush  <= |w_flush;
            if (w_accept) begin
                r_addr  <= pr_addr_i;
                r_is_wr <= pr_wr_i;
                r_hit   <= w_accept_hit;
            end
            for (int i = 0; i < NUM_LINES; i++) begin
                r_line[i] <= w_line_next[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
        localparam logic [ADDR_W-1:0] LP_IDX = ADDR_W'(g);

        mesi_line u_line (
            .i_state      (r_line[g]),
            .i_pr_upgrade (w_upgrade_e && (pr_addr_i == LP_IDX)),
            .i_gnt        (w_gnt && (r_addr == LP_IDX)),
            .i_gnt_cmd    (w_pend_cmd),
            .i_gnt_shared (bus_shared_i),
            .i_snp        (w_snp_valid && (snoop_addr_i == LP_IDX)),
            .i_snp_cmd    (bus_cmd_t'(snoop_cmd_i)),
            .o_next       (w_line_next[g]),
            .o_flush      (w_flush[g]),
            .o_shared     (w_shared[g])
        );

        assign state_o[2*g+1:2*g] = r_line[g];
    end

    assign pr_ready_o     = (r_fsm == ST_DONE);
    assign pr_hit_o       = (r_fsm == ST_DONE) && r_hit;
    assign bus_req_o      = (r_fsm == ST_WAIT_GNT);
    assign bus_cmd_o      = bus_req_o ? w_pend_cmd : 2'b00;
    assign bus_addr_o     = bus_req_o ? r_addr : '0;
    assign snoop_shared_o = r_snoop_shared;
    assign snoop_flush_o  = r_snoop_flush;

endmodule
